// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, next-PC selection, bounds-checked advance
// and a sticky fetch fault that blanks the instruction to a nop until reset.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [31:0] reg_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * (IM_WORDS - 1));

    typedef enum logic {
        ST_RUN,
        ST_FAULTED
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_REG    = 2'b11
    } npc_sel_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic [31:0] branch_off;
    logic [31:0] candidate;
    logic        cand_legal;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{imem_instr[15]}}, imem_instr[15:0], 2'b00};

        unique case (npc_sel_e'(npc_sel))
            NPC_SEQ:    candidate = pc_plus4;
            NPC_BRANCH: candidate = branch_taken ? (pc_plus4 + branch_off) : pc_plus4;
            NPC_JUMP:   candidate = {pc_plus4[31:28], imem_instr[25:0], 2'b00};
            NPC_REG:    candidate = reg_target;
            default:    candidate = pc_plus4;
        endcase

        cand_legal = (candidate[1:0] == 2'b00) &&
                     (candidate >= RESET_PC) && (candidate <= LAST_PC);
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        fault_addr_d = fault_addr_q;

        // Legality only matters on a non-stalled cycle in RUN; FAULTED freezes everything.
        if (state_q == ST_RUN && !stall) begin
            if (cand_legal) begin
                pc_d    = candidate;
                count_d = count_q + 32'd1;
            end else begin
                state_d      = ST_FAULTED;
                fault_addr_d = candidate;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            count_q      <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign pc          = pc_q;
    assign fault       = (state_q == ST_FAULTED);
    assign fault_addr  = fault_addr_q;
    assign fetch_count = count_q;
    assign instr       = fault ? 32'h00000000 : imem_instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a directed vector table, hand-written fault and
// reset sequences, then randomized episodes checked against a behavioural model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h00003000;
    localparam int          IM_WORDS = 1024;
    localparam logic [31:0] TOP_PC   = RESET_PC + 32'(4 * (IM_WORDS - 1));

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [31:0] reg_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    instr_fetch #(
        .RESET_PC(RESET_PC),
        .IM_WORDS(IM_WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_sel     (npc_sel),
        .branch_taken(branch_taken),
        .reg_target  (reg_target),
        .imem_instr  (imem_instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sel;
        logic        bt;
        logic [31:0] rt;
        logic [31:0] im;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[12];

    // Behavioural reference state.
    logic [31:0] m_pc, m_cnt, m_faddr;
    logic        m_fault;

    function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [1:0] sel,
                                               input logic bt, input logic [31:0] rt,
                                               input logic [31:0] im);
        logic [31:0] seq;
        logic [31:0] off;
        seq = cur + 32'd4;
        off = im[15] ? (32'hFFFF0000 | {16'h0, im[15:0]}) : {16'h0, im[15:0]};
        case (sel)
            2'd0:    return seq;
            2'd1:    return bt ? seq + off * 32'd4 : seq;
            2'd2:    return (seq & 32'hF0000000) | ((im & 32'h03FFFFFF) << 2);
            default: return rt;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && (a >= RESET_PC) && (a <= TOP_PC);
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_cnt   = 32'd0;
        m_faddr = 32'd0;
        m_fault = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (!m_fault && !stall) begin
            t = ref_target(m_pc, npc_sel, branch_taken, reg_target, imem_instr);
            if (ref_legal(t)) begin
                m_pc  = t;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_fault = 1'b1;
                m_faddr = t;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pc"}, pc, RESET_PC);
        check({tag, " fault"}, {31'd0, fault}, 32'd0);
        check({tag, " fault_addr"}, fault_addr, 32'd0);
        check({tag, " fetch_count"}, fetch_count, 32'd0);
    endtask

    // Called at posedge+1: pulses reset between edges and checks its immediate effect.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_reset_vals(tag);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic bt,
                         input logic [31:0] rt, input logic [31:0] im);
        stall        = st;
        npc_sel      = sel;
        branch_taken = bt;
        reg_target   = rt;
        imem_instr   = im;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prev_pc;
        int k;

        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset_init");
        reset = 1'b0;

        // Directed table, starting from the reset PC.
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h00000000, 32'h00003004, 32'd1, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h12345678, 32'h00003008, 32'd2, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h00000000, 32'h0000300C, 32'd3, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h00000000, 32'h00003010, 32'd4, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0,    32'h1000FFFC, 32'h00003004, 32'd5, 1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h0,    32'h1000FFFC, 32'h00003008, 32'd6, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h0,    32'h08000C08, 32'h00003008, 32'd6, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h0,    32'h08000C08, 32'h00003008, 32'd6, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0,    32'h08000C08, 32'h00003020, 32'd7, 1'b0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h3FFC, 32'h00000000, 32'h00003FFC, 32'd8, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h3002, 32'h00000000, 32'h00003FFC, 32'd8, 1'b0};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h3000, 32'hCAFEF00D, 32'h00003000, 32'd9, 1'b0};

        prev_pc = RESET_PC;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].st, vecs[i].sel, vecs[i].bt, vecs[i].rt, vecs[i].im);
            #1;
            check($sformatf("vec%0d pc_plus4", i), pc_plus4, prev_pc + 32'd4);
            check($sformatf("vec%0d instr", i), instr, vecs[i].im);
            edge_step();
            check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d fetch_count", i), fetch_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].exp_fault});
            check($sformatf("vec%0d fault_addr", i), fault_addr, 32'd0);
            prev_pc = vecs[i].exp_pc;
        end

        // Jump straight out of reset.
        pulse_reset("reset_a");
        drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h00000C08);
        edge_step();
        check("jump pc", pc, 32'h00003020);
        check("jump fetch_count", fetch_count, 32'd1);

        // Misaligned register target faults; the fault then freezes everything.
        drive(1'b0, 2'd3, 1'b0, 32'h00003002, 32'hDEADBEEF);
        edge_step();
        check("misalign fault", {31'd0, fault}, 32'd1);
        check("misalign fault_addr", fault_addr, 32'h00003002);
        check("misalign pc", pc, 32'h00003020);
        check("misalign instr", instr, 32'h00000000);
        check("misalign fetch_count", fetch_count, 32'd1);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h11111111);
        for (int i = 0; i < 2; i++) begin
            edge_step();
            check($sformatf("hold%0d pc", i), pc, 32'h00003020);
            check($sformatf("hold%0d fault", i), {31'd0, fault}, 32'd1);
            check($sformatf("hold%0d fault_addr", i), fault_addr, 32'h00003002);
            check($sformatf("hold%0d instr", i), instr, 32'h00000000);
        end

        // Async reset while faulted, then the first edge advances normally.
        pulse_reset("reset_faulted");
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        edge_step();
        check("post_reset pc", pc, 32'h00003004);
        check("post_reset fetch_count", fetch_count, 32'd1);

        // One past the last word of instruction memory.
        drive(1'b0, 2'd3, 1'b0, 32'h00004000, 32'h0);
        edge_step();
        check("range fault", {31'd0, fault}, 32'd1);
        check("range fault_addr", fault_addr, 32'h00004000);
        check("range pc", pc, 32'h00003004);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 20; ep++) begin
            pulse_reset($sformatf("ep%0d reset", ep));
            for (int c = 0; c < 40; c++) begin
                k = int'($urandom_range(0, 9));
                stall        = ($urandom_range(0, 9) == 0);
                npc_sel      = 2'($urandom_range(0, 3));
                branch_taken = 1'($urandom_range(0, 1));
                reg_target   = $urandom;
                imem_instr   = $urandom;
                case (npc_sel)
                    2'd1: if (k < 9) imem_instr[15:0] = 16'($urandom_range(0, 64)) - 16'd32;
                    2'd2: if (k < 8) imem_instr[25:0] = 26'((RESET_PC >> 2) + $urandom_range(0, 1023));
                    2'd3: if (k < 8) reg_target = RESET_PC + 32'(4 * $urandom_range(0, 1023));
                    default: ;
                endcase
                #1;
                check($sformatf("ep%0d.%0d pc_plus4", ep, c), pc_plus4, m_pc + 32'd4);
                check($sformatf("ep%0d.%0d instr", ep, c), instr, m_fault ? 32'd0 : imem_instr);
                @(posedge clk);
                model_step();
                #1;
                check($sformatf("ep%0d.%0d pc", ep, c), pc, m_pc);
                check($sformatf("ep%0d.%0d fetch_count", ep, c), fetch_count, m_cnt);
                check($sformatf("ep%0d.%0d fault", ep, c), {31'd0, fault}, {31'd0, m_fault});
                check($sformatf("ep%0d.%0d fault_addr", ep, c), fault_addr, m_faddr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
